// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: accepts one retiring instruction, waits for load data
// when needed, aligns/extends it and drives a registered register-file write port.
module wb_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16,
    parameter int OFF_W   = $clog2(XLEN/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_link_pc,
    input  logic              in_link,
    input  logic              in_mem_to_reg,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [OFF_W-1:0]  in_off,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              misalign_err,
    output logic              timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [REG_AW-1:0] r_rd;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [OFF_W-1:0]  r_off;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;

    logic              w_idle, w_is_load, w_legal, w_uns;
    logic [1:0]        w_size;
    logic [OFF_W-1:0]  w_off;
    logic [XLEN-1:0]   w_sh, w_load;
    logic              w_wr, w_mis, w_to, w_hold;
    logic [REG_AW-1:0] w_waddr;
    logic [XLEN-1:0]   w_wdata;

    assign w_idle    = (r_state == S_IDLE);
    assign in_ready  = w_idle;
    assign w_is_load = ~in_link & in_mem_to_reg;

    // load attributes come from the inputs in IDLE and from the holding regs in WAIT
    assign w_size = w_idle ? in_size     : r_size;
    assign w_uns  = w_idle ? in_unsigned : r_uns;
    assign w_off  = w_idle ? in_off      : r_off;

    // legal loads have the low offset bits clear, so one byte-granular shift serves all sizes
    assign w_sh = mem_rdata >> {w_off, 3'b000};

    always_comb begin
        case (w_size)
            2'b10:   w_load = w_uns ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]));
            2'b01:   w_load = w_uns ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]));
            2'b00:   w_load = (w_uns && XLEN != 32) ? XLEN'(w_sh[31:0])
                                                    : XLEN'($signed(w_sh[31:0]));
            default: w_load = w_sh;
        endcase
    end

    always_comb begin
        case (in_size)
            2'b01:   w_legal = ~in_off[0];
            2'b00:   w_legal = (in_off[1:0] == 2'b00);
            2'b11:   w_legal = (XLEN == 64) && (in_off == '0);
            default: w_legal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_wr        = 1'b0;
        w_mis       = 1'b0;
        w_to        = 1'b0;
        w_hold      = 1'b0;
        w_waddr     = in_rd;
        w_wdata     = in_alu;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (!w_is_load) begin
                        w_wr    = 1'b1;
                        w_wdata = in_link ? in_link_pc : in_alu;
                    end else if (!w_legal) begin
                        w_mis = 1'b1;
                    end else if (mem_rvalid) begin
                        w_wr    = 1'b1;
                        w_wdata = w_load;
                    end else begin
                        w_hold      = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_waddr = r_rd;
                w_wdata = w_load;
                if (mem_rvalid) begin
                    w_wr        = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_to        = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rd         <= '0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_off        <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            rf_we        <= w_wr & (w_waddr != '0);
            misalign_err <= w_mis;
            timeout_err  <= w_to;
            if (w_wr) begin
                rf_waddr <= w_waddr;
                rf_wdata <= w_wdata;
            end
            if (w_hold) begin
                r_rd   <= in_rd;
                r_size <= in_size;
                r_uns  <= in_unsigned;
                r_off  <= in_off;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: one XLEN=32 and one XLEN=64 instance, both TIMEOUT=4.
module tb_wb_stage_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        v32, v64, r32, r64;
    logic [4:0]  rd;
    logic [63:0] alu, lpc, rdata;
    logic        lnk, m2r, uns;
    logic [1:0]  sz;
    logic [2:0]  off;

    logic        rdy32, we32, mis32, to32;
    logic [4:0]  wa32;
    logic [31:0] wd32;
    logic        rdy64, we64, mis64, to64;
    logic [4:0]  wa64;
    logic [63:0] wd64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(32), .REG_AW(5), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_rd(rd),
        .in_alu(alu[31:0]), .in_link_pc(lpc[31:0]), .in_link(lnk), .in_mem_to_reg(m2r),
        .in_size(sz), .in_unsigned(uns), .in_off(off[1:0]), .mem_rvalid(r32),
        .mem_rdata(rdata[31:0]), .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32),
        .misalign_err(mis32), .timeout_err(to32)
    );

    wb_stage_pipe #(.XLEN(64), .REG_AW(5), .TIMEOUT(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .in_rd(rd),
        .in_alu(alu), .in_link_pc(lpc), .in_link(lnk), .in_mem_to_reg(m2r),
        .in_size(sz), .in_unsigned(uns), .in_off(off), .mem_rvalid(r64),
        .mem_rdata(rdata), .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64),
        .misalign_err(mis64), .timeout_err(to64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [4:0] r, input logic [1:0] s, input logic u,
                            input logic [2:0] o);
        rd = r; lnk = 1'b0; m2r = 1'b1; sz = s; uns = u; off = o;
    endtask

    initial begin
        rst = 1'b1; v32 = 0; v64 = 0; r32 = 0; r64 = 0; rd = 0; alu = 0; lpc = 0;
        rdata = 0; lnk = 0; m2r = 0; uns = 0; sz = 0; off = 0;
        tick(); tick();
        chk("rst_ready", rdy32, 1);
        chk("rst_we", we32, 0);
        chk("rst_wdata", wd32, 0);
        chk("rst_errs", {mis32, to32, mis64, to64}, 0);
        rst = 1'b0;
        tick();

        // back-to-back ALU writes
        rd = 3; alu = 64'h1234; v32 = 1;
        tick();
        chk("alu1_we", we32, 1);
        chk("alu1_addr", wa32, 3);
        chk("alu1_data", wd32, 32'h0000_1234);
        rd = 4; alu = 64'h55;
        tick();
        chk("alu2_we", we32, 1);
        chk("alu2_data", {wa32, wd32}, {5'd4, 32'h55});
        v32 = 0;
        tick();
        chk("alu_we_drop", we32, 0);

        // signed byte load, data three cycles after accept, attributes changed while waiting
        set_load(5, 2'b10, 0, 3'd2); v32 = 1;
        tick();
        v32 = 0; sz = 2'b00; off = 0; uns = 1; rd = 9;
        chk("ldb_wait_ready", rdy32, 0);
        tick();
        chk("ldb_wait_we", we32, 0);
        tick();
        r32 = 1; rdata = 64'h0080_0000;
        tick();
        r32 = 0;
        chk("ldb_s_we", we32, 1);
        chk("ldb_s_data", {wa32, wd32}, {5'd5, 32'hFFFF_FF80});
        chk("ldb_s_ready", rdy32, 1);

        // unsigned byte, data in the accept cycle
        set_load(5, 2'b10, 1, 3'd2); v32 = 1; r32 = 1; rdata = 64'h0080_0000;
        tick();
        v32 = 0; r32 = 0;
        chk("ldb_u_data", {we32, wd32}, {1'b1, 32'h0000_0080});

        // XLEN=64 loads
        set_load(8, 2'b00, 0, 3'd4); v64 = 1; r64 = 1; rdata = 64'h8000_0000_0000_0000;
        tick();
        chk("ldw64_s", {we64, wd64}, {1'b1, 64'hFFFF_FFFF_8000_0000});
        uns = 1;
        tick();
        chk("ldw64_u", wd64, 64'h0000_0000_8000_0000);
        sz = 2'b01; uns = 0; off = 6; rdata = 64'hBEEF_0000_0000_0000;
        tick();
        chk("ldh64_s", wd64, 64'hFFFF_FFFF_FFFF_BEEF);
        sz = 2'b11; off = 0; rdata = 64'h8123_4567_89AB_CDEF;
        tick();
        chk("ldd64", wd64, 64'h8123_4567_89AB_CDEF);
        r64 = 0; lnk = 1; lpc = 64'h40; alu = 64'h99; sz = 2'b01; off = 1;
        tick();
        v64 = 0;
        chk("link64", {we64, mis64, wd64}, {2'b10, 64'h40});

        // misaligned / illegal loads
        set_load(6, 2'b01, 0, 3'd1); v32 = 1;
        tick();
        v32 = 0;
        chk("mis_half", {mis32, we32, rdy32}, 3'b101);
        tick();
        chk("mis_pulse_end", mis32, 0);
        set_load(6, 2'b11, 0, 3'd0); v32 = 1;
        tick();
        v32 = 0;
        chk("mis_dword32", {mis32, we32, rdy32}, 3'b101);

        // timeout after four WAIT cycles
        set_load(7, 2'b10, 0, 3'd0); v32 = 1;
        tick();
        v32 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_waiting", {to32, rdy32}, 2'b00);
        end
        tick();
        chk("to_pulse", {to32, we32, rdy32}, 3'b101);
        tick();
        chk("to_pulse_end", to32, 0);

        // data on the fourth WAIT cycle beats the timeout
        v32 = 1;
        tick();
        v32 = 0;
        tick(); tick(); tick();
        r32 = 1; rdata = 64'hA5;
        tick();
        r32 = 0;
        chk("to_data_wins", {to32, we32, wd32}, {2'b01, 32'hFFFF_FFA5});

        // rd=0 suppresses the write
        rd = 0; lnk = 0; m2r = 0; alu = 64'h77; v32 = 1;
        tick();
        v32 = 0;
        chk("rd0_no_we", we32, 0);

        // reset in WAIT abandons the load
        set_load(10, 2'b10, 0, 3'd0); v32 = 1;
        tick();
        v32 = 0;
        tick();
        rst = 1;
        #1;
        chk("rst_wait", {rdy32, we32, mis32, to32, wd32}, {4'b1000, 32'h0});
        tick();
        rst = 0;
        r32 = 1; rdata = 64'hFF;
        tick();
        r32 = 0;
        chk("late_rvalid", {we32, mis32, to32, rdy32}, 4'b0001);
        tick();
        chk("late_quiet", {we32, to32}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
